raster_count10: RTL



---
 rtl/raster_pkg.sv | 7 +
 rtl/tc_detect.sv | 14 +
 rtl/raster_count10.sv | 81 ++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared constants and state encoding for the raster interval counter.
package raster_pkg;
  localparam int                CNT_W  = 10;
  localparam logic [CNT_W-1:0]  TC_VAL = 10'h3FF;

  typedef enum logic {RUNNING = 1'b0, HALTED = 1'b1} state_e;
endpackage

// File: rtl/tc_detect.sv
// Ten-input all-ones detect: NAND4 + NAND4 + NAND2 merged by a NOR3.
module tc_detect
  import raster_pkg::*;
(
  input  logic [CNT_W-1:0] q_i,
  output logic             all_ones_o
);
  logic nand_lo, nand_mid, nand_hi;

  assign nand_lo    = ~&q_i[3:0];
  assign nand_mid   = ~&q_i[7:4];
  assign nand_hi    = ~&q_i[9:8];
  assign all_ones_o = ~(nand_lo | nand_mid | nand_hi);
endmodule

// File: rtl/raster_count10.sv
// Loadable 10-bit interval counter with terminal-count pulse, auto-reload and IRQ latch.
// Optional one-shot halt mode is compiled in with RASTER_COUNT10_ONESHOT_EN.
module raster_count10
  import raster_pkg::*;
(
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             LD,
  input  logic [CNT_W-1:0] D,
  input  logic             EN,
  input  logic             ACK,
`ifdef RASTER_COUNT10_ONESHOT_EN
  input  logic             ONESHOT,
`endif
  output logic [CNT_W-1:0] Q,
  output logic             TC,
  output logic             IRQ,
  output logic             RUN
);
  state_e           state_q;
  logic [CNT_W-1:0] q_q, reload_q;
  logic             tc_q, irq_q, run_q;
  logic             all_ones, wrap, oneshot;

`ifdef RASTER_COUNT10_ONESHOT_EN
  assign oneshot = ONESHOT;
`else
  assign oneshot = 1'b0;
`endif

  tc_detect u_tc_detect (
    .q_i        (q_q),
    .all_ones_o (all_ones)
  );

  // A load on the same edge always suppresses the wrap.
  assign wrap = !LD && (state_q == RUNNING) && EN && all_ones;

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      state_q  <= RUNNING;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
      run_q    <= 1'b1;
    end else begin
      if (wrap)     irq_q <= 1'b1;
      else if (ACK) irq_q <= 1'b0;

      if (LD) begin
        q_q      <= D;
        reload_q <= D;
        tc_q     <= 1'b0;
        state_q  <= RUNNING;
        run_q    <= 1'b1;
      end else begin
        tc_q <= wrap;
        case (state_q)
          RUNNING: begin
            if (wrap) begin
              q_q <= reload_q;
              if (oneshot) begin
                state_q <= HALTED;
                run_q   <= 1'b0;
              end
            end else if (EN) begin
              q_q <= q_q + 1'b1;
            end
          end
          default: ; // halted: hold until load or reset
        endcase
      end
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign IRQ = irq_q;
  assign RUN = run_q;
endmodule
